// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: registers the winning request, issues it to memory, routes the response.
// Optional abort of stalled transactions when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
    parameter int unsigned FIXED_PRIO     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_ce,
    input  logic [31:0] m0_addr,
    input  logic [2:0]  m0_funct3,
    input  logic        m0_we,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_busy,
    output logic        m0_valid,
    output logic        m0_err,
    input  logic        m1_ce,
    input  logic [31:0] m1_addr,
    input  logic [2:0]  m1_funct3,
    input  logic        m1_we,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_busy,
    output logic        m1_valid,
    output logic        m1_err,
    output logic        mem_ce,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_funct3,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy,
    input  logic        mem_valid
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        grant, capture, abort;
    logic [31:0] mem_addr_q, mem_wdata_q, m0_rdata_q, m1_rdata_q;
    logic [2:0]  mem_funct3_q;
    logic        mem_we_q;
    logic        serving0, serving1;
    logic        tmo_hit;

    // Completion is driven purely by mem_valid; the memory busy flag is informational here.
    logic unused_mem_busy;
    assign unused_mem_busy = mem_busy;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic        timeout_q;

    assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == StIssue) begin
                tmo_cnt_q <= '0;
            end else if (state_q == StWait) begin
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end
            timeout_q <= abort;
        end
    end

    assign m0_err = (state_q == StResp) && !owner_q && timeout_q;
    assign m1_err = (state_q == StResp) && owner_q && timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
    assign m0_err         = 1'b0;
    assign m1_err         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant   = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (m0_ce || m1_ce) begin
                    grant   = 1'b1;
                    state_d = StIssue;
                    if (m0_ce && m1_ce) begin
                        owner_d = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
                    end else begin
                        owner_d = m1_ce;
                    end
                end
            end
            StIssue: begin
                if (mem_valid) begin
                    capture = 1'b1;
                    state_d = StResp;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_valid) begin
                    capture = 1'b1;
                    state_d = StResp;
                end else if (tmo_hit) begin
                    abort   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                last_d  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            mem_addr_q   <= '0;
            mem_funct3_q <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            if (grant) begin
                mem_addr_q   <= owner_d ? m1_addr   : m0_addr;
                mem_funct3_q <= owner_d ? m1_funct3 : m0_funct3;
                mem_we_q     <= owner_d ? m1_we     : m0_we;
                mem_wdata_q  <= owner_d ? m1_wdata  : m0_wdata;
            end
            // Written on the completion edge so the data is already valid during RESP.
            if (capture || abort) begin
                if (owner_q) begin
                    m1_rdata_q <= abort ? 32'h0 : mem_rdata;
                end else begin
                    m0_rdata_q <= abort ? 32'h0 : mem_rdata;
                end
            end
        end
    end

    assign serving0 = (state_q != StIdle) && !owner_q;
    assign serving1 = (state_q != StIdle) && owner_q;

    assign m0_busy    = (m0_ce && !serving0) || serving0;
    assign m1_busy    = (m1_ce && !serving1) || serving1;
    assign m0_valid   = (state_q == StResp) && !owner_q;
    assign m1_valid   = (state_q == StResp) && owner_q;
    assign m0_rdata   = m0_rdata_q;
    assign m1_rdata   = m1_rdata_q;
    assign mem_ce     = (state_q == StIssue);
    assign mem_addr   = mem_addr_q;
    assign mem_funct3 = mem_funct3_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle-exact vector table plus directed sequences.
// Round-robin and fixed-priority instances share the same stimulus.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_ce = 1'b0, m1_ce = 1'b0, m0_we = 1'b0, m1_we = 1'b1;
    logic [31:0] m0_addr = 32'h100, m1_addr = 32'h2000_0004;
    logic [2:0]  m0_funct3 = 3'b010, m1_funct3 = 3'b010;
    logic [31:0] m0_wdata = 32'h0, m1_wdata = 32'h1234_5678;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_valid = 1'b0;

    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
    logic        m0_busy, m0_valid, m0_err, m1_busy, m1_valid, m1_err, mem_ce, mem_we;
    logic [2:0]  mem_funct3;

    logic [31:0] p_m0_rdata, p_m1_rdata, p_mem_addr, p_mem_wdata;
    logic        p_m0_busy, p_m0_valid, p_m0_err, p_m1_busy, p_m1_valid, p_m1_err;
    logic        p_mem_ce, p_mem_we;
    logic [2:0]  p_mem_funct3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(8)) dut_rr (
        .clk(clk), .reset(reset),
        .m0_ce(m0_ce), .m0_addr(m0_addr), .m0_funct3(m0_funct3), .m0_we(m0_we),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_busy(m0_busy), .m0_valid(m0_valid),
        .m0_err(m0_err),
        .m1_ce(m1_ce), .m1_addr(m1_addr), .m1_funct3(m1_funct3), .m1_we(m1_we),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_busy(m1_busy), .m1_valid(m1_valid),
        .m1_err(m1_err),
        .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_funct3(mem_funct3), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy(1'b0), .mem_valid(mem_valid)
    );

    mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(8)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_ce(m0_ce), .m0_addr(m0_addr), .m0_funct3(m0_funct3), .m0_we(m0_we),
        .m0_wdata(m0_wdata), .m0_rdata(p_m0_rdata), .m0_busy(p_m0_busy),
        .m0_valid(p_m0_valid), .m0_err(p_m0_err),
        .m1_ce(m1_ce), .m1_addr(m1_addr), .m1_funct3(m1_funct3), .m1_we(m1_we),
        .m1_wdata(m1_wdata), .m1_rdata(p_m1_rdata), .m1_busy(p_m1_busy),
        .m1_valid(p_m1_valid), .m1_err(p_m1_err),
        .mem_ce(p_mem_ce), .mem_addr(p_mem_addr), .mem_funct3(p_mem_funct3),
        .mem_we(p_mem_we), .mem_wdata(p_mem_wdata), .mem_rdata(mem_rdata), .mem_busy(1'b0),
        .mem_valid(mem_valid)
    );

    // in_bits = {reset, m0_ce, m1_ce, mem_valid}; exp_bits = {mem_ce, v0, v1, busy0, busy1}
    typedef struct {
        logic [3:0]  in_bits;
        logic [31:0] mrd;
        logic [4:0]  exp_bits;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [3:0] ib, input logic [31:0] mrd, input logic [4:0] eb,
                           input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t v;
        v.in_bits = ib; v.mrd = mrd; v.exp_bits = eb; v.rd0 = rd0; v.rd1 = rd1;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic c0, input logic c1, input logic mv, input logic [31:0] mrd);
        @(negedge clk);
        m0_ce = c0; m1_ce = c1; mem_valid = mv; mem_rdata = mrd;
        #1;
    endtask

    initial begin
        // Single port 0 read, valid three cycles after mem_ce, idle mem_valid ignored.
        add_vec(4'b1000, 32'h0,         5'b00000, 32'h0,         32'h0);
        add_vec(4'b0100, 32'h0,         5'b00010, 32'h0,         32'h0);
        add_vec(4'b0100, 32'h0,         5'b10010, 32'h0,         32'h0);
        add_vec(4'b0100, 32'h0,         5'b00010, 32'h0,         32'h0);
        add_vec(4'b0100, 32'h0,         5'b00010, 32'h0,         32'h0);
        add_vec(4'b0101, 32'hDEADBEEF, 5'b00010, 32'h0,         32'h0);
        add_vec(4'b0000, 32'h0,         5'b01010, 32'hDEADBEEF, 32'h0);
        add_vec(4'b0001, 32'h11111111, 5'b00000, 32'hDEADBEEF, 32'h0);
        add_vec(4'b0000, 32'h0,         5'b00000, 32'hDEADBEEF, 32'h0);
        // Reset, then simultaneous requests alternate 0,1,0,1; mem_valid in ISSUE accepted.
        add_vec(4'b1000, 32'h0,         5'b00000, 32'h0,         32'h0);
        add_vec(4'b0110, 32'h0,         5'b00011, 32'h0,         32'h0);
        add_vec(4'b0110, 32'h0,         5'b10011, 32'h0,         32'h0);
        add_vec(4'b0111, 32'hA0A0A0A0, 5'b00011, 32'h0,         32'h0);
        add_vec(4'b0010, 32'h0,         5'b01011, 32'hA0A0A0A0, 32'h0);
        add_vec(4'b0010, 32'h0,         5'b00001, 32'hA0A0A0A0, 32'h0);
        add_vec(4'b0011, 32'hB1B1B1B1, 5'b10001, 32'hA0A0A0A0, 32'h0);
        add_vec(4'b0000, 32'h0,         5'b00101, 32'hA0A0A0A0, 32'hB1B1B1B1);
        add_vec(4'b0110, 32'h0,         5'b00011, 32'hA0A0A0A0, 32'hB1B1B1B1);
        add_vec(4'b0111, 32'hC0C0C0C0, 5'b10011, 32'hA0A0A0A0, 32'hB1B1B1B1);
        add_vec(4'b0010, 32'h0,         5'b01011, 32'hC0C0C0C0, 32'hB1B1B1B1);
        add_vec(4'b0010, 32'h0,         5'b00001, 32'hC0C0C0C0, 32'hB1B1B1B1);
        add_vec(4'b0011, 32'hD1D1D1D1, 5'b10001, 32'hC0C0C0C0, 32'hB1B1B1B1);
        add_vec(4'b0000, 32'h0,         5'b00101, 32'hC0C0C0C0, 32'hD1D1D1D1);
        add_vec(4'b0000, 32'h0,         5'b00000, 32'hC0C0C0C0, 32'hD1D1D1D1);

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset     = vecs[i].in_bits[3];
            m0_ce     = vecs[i].in_bits[2];
            m1_ce     = vecs[i].in_bits[1];
            mem_valid = vecs[i].in_bits[0];
            mem_rdata = vecs[i].mrd;
            #1;
            check($sformatf("v%0d mem_ce", i),   32'(mem_ce),   32'(vecs[i].exp_bits[4]));
            check($sformatf("v%0d m0_valid", i), 32'(m0_valid), 32'(vecs[i].exp_bits[3]));
            check($sformatf("v%0d m1_valid", i), 32'(m1_valid), 32'(vecs[i].exp_bits[2]));
            check($sformatf("v%0d m0_busy", i),  32'(m0_busy),  32'(vecs[i].exp_bits[1]));
            check($sformatf("v%0d m1_busy", i),  32'(m1_busy),  32'(vecs[i].exp_bits[0]));
            check($sformatf("v%0d m0_rdata", i), m0_rdata,      vecs[i].rd0);
            check($sformatf("v%0d m1_rdata", i), m1_rdata,      vecs[i].rd1);
        end

        // Both held high: fixed priority keeps serving port 0, round-robin alternates.
        for (int t = 0; t < 9; t++) begin
            step(1'b1, 1'b1, 1'b1, 32'h33333333);
            check("fp m1_busy held", 32'(p_m1_busy), 32'h1);
            if (t % 3 == 1) check("fp mem_ce", 32'(p_mem_ce), 32'h1);
            if (t % 3 == 2) begin
                check("fp m0_valid", 32'(p_m0_valid), 32'h1);
                check("fp m1_valid", 32'(p_m1_valid), 32'h0);
                check("fp m0_rdata", p_m0_rdata, 32'h33333333);
                check("rr m0_valid", 32'(m0_valid), 32'((t / 3) % 2 == 0));
                check("rr m1_valid", 32'(m1_valid), 32'((t / 3) % 2 == 1));
            end
        end

        // Port 1 write: registered fields stable while requester inputs change mid-WAIT.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("wr busy1", 32'(m1_busy), 32'h1);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("wr issue mem_ce", 32'(mem_ce), 32'h1);
        check("wr issue addr", mem_addr, 32'h2000_0004);
        check("wr issue funct3", 32'(mem_funct3), 32'h2);
        check("wr issue we", 32'(mem_we), 32'h1);
        check("wr issue wdata", mem_wdata, 32'h1234_5678);
        @(negedge clk);
        m1_addr = 32'hFFFF_0000; m1_wdata = 32'h0; m1_we = 1'b0; m1_funct3 = 3'b000;
        m1_ce = 1'b0;
        #1;
        check("wr wait addr", mem_addr, 32'h2000_0004);
        check("wr wait wdata", mem_wdata, 32'h1234_5678);
        check("wr wait we", 32'(mem_we), 32'h1);
        check("wr wait busy1", 32'(m1_busy), 32'h1);
        step(1'b0, 1'b0, 1'b1, 32'h0BADF00D);
        check("wr wait2 funct3", 32'(mem_funct3), 32'h2);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("wr resp valid1", 32'(m1_valid), 32'h1);
        check("wr resp addr", mem_addr, 32'h2000_0004);
        check("wr resp rdata1", m1_rdata, 32'h0BADF00D);
        m1_addr = 32'h2000_0004; m1_wdata = 32'h1234_5678; m1_we = 1'b1; m1_funct3 = 3'b010;

        // Reset during WAIT, stray mem_valid afterwards, then a normal transaction.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b1; m0_ce = 1'b0;
        #1;
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_we", 32'(mem_we), 32'h0);
        check("rst mem_ce", 32'(mem_ce), 32'h0);
        check("rst m0_busy", 32'(m0_busy), 32'h0);
        check("rst m0_rdata", m0_rdata, 32'h0);
        check("rst m1_rdata", m1_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h55555555;
        #1;
        check("rst stray valid0", 32'(m0_valid), 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("rst stray valid0b", 32'(m0_valid), 32'h0);
        check("rst stray rdata0", m0_rdata, 32'h0);
        check("rst stray mem_ce", 32'(mem_ce), 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("post rst mem_ce", 32'(mem_ce), 32'h1);
        check("post rst addr", mem_addr, 32'h100);
        step(1'b1, 1'b0, 1'b1, 32'h600DCAFE);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("post rst valid0", 32'(m0_valid), 32'h1);
        check("post rst rdata0", m0_rdata, 32'h600DCAFE);
        check("post rst err0", 32'(m0_err), 32'h0);

        // Memory never answers.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef MEM_ARB_TIMEOUT_EN
        for (int n = 0; n < 8; n++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            check("tmo wait valid0", 32'(m0_valid), 32'h0);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("tmo valid0", 32'(m0_valid), 32'h1);
        check("tmo err0", 32'(m0_err), 32'h1);
        check("tmo rdata0", m0_rdata, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h77777777);
        check("tmo after valid0", 32'(m0_valid), 32'h0);
        check("tmo after err0", 32'(m0_err), 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("tmo late rdata0", m0_rdata, 32'h0);
        check("tmo late valid0", 32'(m0_valid), 32'h0);
`else
        for (int n = 0; n < 20; n++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            check("notmo valid0", 32'(m0_valid), 32'h0);
            check("notmo err0", 32'(m0_err), 32'h0);
            check("notmo busy0", 32'(m0_busy), 32'h1);
        end
        step(1'b1, 1'b0, 1'b1, 32'h77777777);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("notmo late valid0", 32'(m0_valid), 32'h1);
        check("notmo late err0", 32'(m0_err), 32'h0);
        check("notmo late rdata0", m0_rdata, 32'h77777777);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
